alsu_param: RTL and testbench
=============================

// Module: alsu_param
// PURPOSE
//  Parametrised next-generation ALSU: signed W-bit operands, 2W-bit signed result, registered inputs and output.
//  Adds an in_valid/out_valid qualifier, a programmable LED blink divider and a saturating invalid-op counter.
//  Drop-in core for the ALSU datapath; leds/out/invalid keep the existing bound-assertion contract.
// PARAMETERS
//  W             3      operand width (signed); out is 2W bits
//  INPUT_PRIORITY "A"   "A" or "B": wins when both bypass_* or both red_op_* are set
//  FULL_ADDER    1      1: add uses cin; 0: cin ignored
//  LED_W         16     leds width
//  BLINK_DIV     1      cycles between leds toggles while invalid (>=1)
//  ERR_CNT_W     8      err_cnt width
// PORTS
//  clk        in   1      clock, all flops on rising edge
//  rst        in   1      asynchronous reset, active-high
//  in_valid   in   1      qualifies all operation inputs this cycle
//  A, B       in   W      signed operands
//  cin        in   1      carry-in for add
//  serial_in  in   1      fill bit for shift
//  red_op_A   in   1      reduction on A (opcodes 0/1 only)
//  red_op_B   in   1      reduction on B (opcodes 0/1 only)
//  opcode     in   3      0 OR,1 XOR,2 ADD,3 MUL,4 SHIFT,5 ROTATE,6/7 invalid
//  bypass_A   in   1      out <= A (sign-extended)
//  bypass_B   in   1      out <= B (sign-extended)
//  direction  in   1      1 left, 0 right (shift/rotate)
//  err_clr    in   1      synchronous clear of err_cnt
//  out        out  2W     signed result
//  out_valid  out  1      1-cycle pulse, out/invalid updated this cycle
//  invalid    out  1      result of last accepted op was invalid
//  leds       out  LED_W  0 when !invalid; blinks while invalid
//  err_cnt    out  ERR_CNT_W  saturating count of accepted invalid ops
// BEHAVIOUR
//  Reset (async, any time incl. mid-op/mid-blink): all input regs, out, out_valid, invalid, leds, err_cnt, blink counter -> 0.
//  Pipeline: stage 1 registers inputs + in_valid; stage 2 computes and registers out. Latency 2: op at edge N -> out_valid at N+2.
//  in_valid=0: stage 2 holds out and invalid; out_valid=0; err_cnt unchanged; blinking continues.
//  Invalid op: opcode 6/7, or (red_op_A|red_op_B) with opcode not 0/1. Precedence: invalid > bypass > opcode.
//  Invalid op: out <= 0, invalid <= 1, err_cnt += 1 (saturates at all-ones).
//  Bypass: both set -> INPUT_PRIORITY operand. Sign-extend to 2W.
//  OR/XOR: red_op_* -> reduction of chosen operand (both set -> INPUT_PRIORITY); else A op B bitwise. Zero-extend to 2W.
//  ADD: sext(A)+sext(B)+(FULL_ADDER?cin:0), 2W bits, no overflow possible.
//  MUL: signed A*B, full 2W bits.
//  SHIFT operates on current out: left {out[2W-2:0],serial_in}; right {serial_in,out[2W-1:1]}.
//  ROTATE: left {out[2W-2:0],out[2W-1]}; right {out[0],out[2W-1:1]}.
//  Valid op: invalid <= 0; leds <= 0 same edge; blink counter <= 0.
//  Blink: while invalid=1, counter counts 0..BLINK_DIV-1; on reaching BLINK_DIV-1, leds <= ~leds, counter <= 0.
//   First toggle (0 -> all-ones) occurs BLINK_DIV cycles after invalid rises. BLINK_DIV=1 toggles every cycle.
//  New invalid op while already invalid: counter and leds phase not restarted.
//  err_clr: err_cnt <= 0; err_clr and increment same cycle -> 0 (clear wins).
//  out never X/Z after reset.
// TESTING (W=3, LED_W=16, ERR_CNT_W=8 unless noted)
//  1 ADD A=3,B=2,cin=1,FULL_ADDER=1 -> out=6 at N+2, out_valid 1 cycle, invalid=0, leds=0.
//  2 MUL A=-4,B=3 -> out=-12 (6'b110100); bypass_A=bypass_B=1, A=-2,B=1,prio "A" -> out=-2.
//  3 out=6'b000001; SHIFT left serial_in=1 -> 000011; ROTATE right -> 100001.
//  4 opcode=6 -> out=0, invalid=1, leds FFFF,0000,FFFF each cycle (BLINK_DIV=1); BLINK_DIV=4 -> toggles every 4 cycles; next valid op -> leds=0.
//  5 red_op_A=1 with opcode=2 -> invalid=1, err_cnt=1; ERR_CNT_W=2, 5 invalid ops -> err_cnt=3; err_clr with invalid op same cycle -> 0.
//  6 rst pulse mid-blink and mid-pipeline (in_valid in flight) -> all outputs 0 immediately; no out_valid after release.

Source files
------------

// File: rtl/alsu_param.sv
// alsu_param: parametrised two-stage ALSU core.
// Stage 1 registers the operation inputs and in_valid; stage 2 computes the
// result from those registers and holds out/invalid until the next accepted
// operation. The leds blink while the last accepted operation was invalid,
// and err_cnt keeps a saturating count of accepted invalid operations.
module alsu_param #(
    parameter int W              = 3,
    parameter     INPUT_PRIORITY = "A",
    parameter bit FULL_ADDER     = 1'b1,
    parameter int LED_W          = 16,
    parameter int BLINK_DIV      = 1,
    parameter int ERR_CNT_W      = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic signed [W-1:0]     A,
    input  logic signed [W-1:0]     B,
    input  logic                    cin,
    input  logic                    serial_in,
    input  logic                    red_op_A,
    input  logic                    red_op_B,
    input  logic [2:0]              opcode,
    input  logic                    bypass_A,
    input  logic                    bypass_B,
    input  logic                    direction,
    input  logic                    err_clr,
    output logic signed [2*W-1:0]   out,
    output logic                    out_valid,
    output logic                    invalid,
    output logic [LED_W-1:0]        leds,
    output logic [ERR_CNT_W-1:0]    err_cnt
);

    typedef enum logic [2:0] {
        OP_OR     = 3'd0,
        OP_XOR    = 3'd1,
        OP_ADD    = 3'd2,
        OP_MUL    = 3'd3,
        OP_SHIFT  = 3'd4,
        OP_ROTATE = 3'd5,
        OP_INV6   = 3'd6,
        OP_INV7   = 3'd7
    } opcode_e;

    localparam int OW     = 2 * W;
    localparam bit PRIO_A = (INPUT_PRIORITY == "A");
    localparam int CNT_W  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_DIV - 1);

    // Stage 1 registers
    logic [W-1:0]   a_q, b_q;
    logic           cin_q, serial_q, red_a_q, red_b_q;
    logic           byp_a_q, byp_b_q, dir_q, err_clr_q, valid_q;
    opcode_e        opcode_q;

    // Stage 2 registers and next-state
    logic [OW-1:0]        out_q, out_d;
    logic                 out_valid_q, invalid_q;
    logic [LED_W-1:0]     leds_q;
    logic [CNT_W-1:0]     blink_cnt_q;
    logic [ERR_CNT_W-1:0] err_q;
    logic                 invalid_op;

    logic [OW-1:0] a_ext, b_ext, cin_ext;
    logic          use_a_red, use_a_byp, cin_eff;

    assign a_ext     = {{W{a_q[W-1]}}, a_q};
    assign b_ext     = {{W{b_q[W-1]}}, b_q};
    assign cin_eff   = FULL_ADDER ? cin_q : 1'b0;
    assign cin_ext   = {{(OW-1){1'b0}}, cin_eff};
    // When both selects are set, the priority operand wins.
    assign use_a_red = red_a_q && (PRIO_A || !red_b_q);
    assign use_a_byp = byp_a_q && (PRIO_A || !byp_b_q);

    // Stage 1: capture every operation input together with its qualifier.
    // err_clr travels with the operation so a clear and an invalid op
    // presented in the same cycle meet at the same err_cnt update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q       <= '0;
            b_q       <= '0;
            cin_q     <= 1'b0;
            serial_q  <= 1'b0;
            red_a_q   <= 1'b0;
            red_b_q   <= 1'b0;
            opcode_q  <= OP_OR;
            byp_a_q   <= 1'b0;
            byp_b_q   <= 1'b0;
            dir_q     <= 1'b0;
            err_clr_q <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            a_q       <= A;
            b_q       <= B;
            cin_q     <= cin;
            serial_q  <= serial_in;
            red_a_q   <= red_op_A;
            red_b_q   <= red_op_B;
            opcode_q  <= opcode_e'(opcode);
            byp_a_q   <= bypass_A;
            byp_b_q   <= bypass_B;
            dir_q     <= direction;
            err_clr_q <= err_clr;
            valid_q   <= in_valid;
        end
    end

    // Stage 2 combinational: classify the op and compute the next result.
    always_comb begin
        // NOTE: defaults first so no path through this block infers a latch.
        out_d      = '0;
        invalid_op = (opcode_q == OP_INV6) || (opcode_q == OP_INV7) ||
                     ((red_a_q || red_b_q) && (opcode_q != OP_OR) && (opcode_q != OP_XOR));
        if (invalid_op) begin
            out_d = '0;
        end else if (byp_a_q || byp_b_q) begin
            out_d = use_a_byp ? a_ext : b_ext;
        end else begin
            unique case (opcode_q)
                OP_OR: begin
                    if (red_a_q || red_b_q)
                        out_d = {{(OW-1){1'b0}}, (use_a_red ? |a_q : |b_q)};
                    else
                        out_d = {{W{1'b0}}, a_q | b_q};
                end
                OP_XOR: begin
                    if (red_a_q || red_b_q)
                        out_d = {{(OW-1){1'b0}}, (use_a_red ? ^a_q : ^b_q)};
                    else
                        out_d = {{W{1'b0}}, a_q ^ b_q};
                end
                OP_ADD:    out_d = a_ext + b_ext + cin_ext;
                // Low 2W bits of the sign-extended product are the exact signed product.
                OP_MUL:    out_d = a_ext * b_ext;
                OP_SHIFT:  out_d = dir_q ? {out_q[OW-2:0], serial_q}
                                         : {serial_q, out_q[OW-1:1]};
                OP_ROTATE: out_d = dir_q ? {out_q[OW-2:0], out_q[OW-1]}
                                         : {out_q[0], out_q[OW-1:1]};
                default:   out_d = '0;
            endcase
        end
    end

    // Stage 2 register: out and invalid only move on an accepted op.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
            invalid_q   <= 1'b0;
        end else begin
            out_valid_q <= valid_q;
            if (valid_q) begin
                out_q     <= out_d;
                invalid_q <= invalid_op;
            end
        end
    end

    // LED blinker: cleared by a valid op, free-running divider while invalid.
    // A further invalid op while already invalid keeps the current phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            leds_q      <= '0;
            blink_cnt_q <= '0;
        end else if (valid_q && !invalid_op) begin
            leds_q      <= '0;
            blink_cnt_q <= '0;
        end else if (invalid_q) begin
            if (blink_cnt_q == BLINK_LAST) begin
                leds_q      <= ~leds_q;
                blink_cnt_q <= '0;
            end else begin
                blink_cnt_q <= blink_cnt_q + 1'b1;
            end
        end
    end

    // Saturating invalid-op counter; a clear beats a simultaneous increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= '0;
        end else if (err_clr_q) begin
            err_q <= '0;
        end else if (valid_q && invalid_op && (err_q != '1)) begin
            err_q <= err_q + 1'b1;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign invalid   = invalid_q;
    assign leds      = leds_q;
    assign err_cnt   = err_q;

endmodule

// File: tb/tb_alsu_param.sv
// tb_alsu_param: scoreboard bench for alsu_param.
// dut : W=3, INPUT_PRIORITY "A", BLINK_DIV=1, ERR_CNT_W=8
// dut2: W=3, INPUT_PRIORITY "B", BLINK_DIV=4, ERR_CNT_W=2
// Both see the same stimulus; expected outputs for each are queued when an
// op is driven and compared when out_valid appears.
module tb_alsu_param;

    typedef struct {
        logic [5:0] o1;
        logic [5:0] o2;
        logic       inv;
    } exp_t;

    logic clk, rst, in_valid, cin, serial_in, red_op_A, red_op_B;
    logic bypass_A, bypass_B, direction, err_clr;
    logic signed [2:0] A, B;
    logic [2:0]  opcode;
    logic signed [5:0] out1, out2;
    logic        ov1, ov2, inv1, inv2;
    logic [15:0] leds1, leds2;
    logic [7:0]  err1;
    logic [1:0]  err2;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   exp_err1 = 0;
    int   exp_err2 = 0;

    alsu_param #(.W(3), .INPUT_PRIORITY("A"), .FULL_ADDER(1'b1), .LED_W(16),
                 .BLINK_DIV(1), .ERR_CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .A(A), .B(B), .cin(cin),
        .serial_in(serial_in), .red_op_A(red_op_A), .red_op_B(red_op_B),
        .opcode(opcode), .bypass_A(bypass_A), .bypass_B(bypass_B),
        .direction(direction), .err_clr(err_clr), .out(out1), .out_valid(ov1),
        .invalid(inv1), .leds(leds1), .err_cnt(err1));

    alsu_param #(.W(3), .INPUT_PRIORITY("B"), .FULL_ADDER(1'b1), .LED_W(16),
                 .BLINK_DIV(4), .ERR_CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .A(A), .B(B), .cin(cin),
        .serial_in(serial_in), .red_op_A(red_op_A), .red_op_B(red_op_B),
        .opcode(opcode), .bypass_A(bypass_A), .bypass_B(bypass_B),
        .direction(direction), .err_clr(err_clr), .out(out2), .out_valid(ov2),
        .invalid(inv2), .leds(leds2), .err_cnt(err2));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Scoreboard: every out_valid pops one expectation.
    always @(negedge clk) begin
        if (ov1 || ov2) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_out_valid: got ov1=%b ov2=%b expected none", ov1, ov2);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if ({ov1, ov2, out1, out2, inv1, inv2} !== {2'b11, e.o1, e.o2, e.inv, e.inv}) begin
                    miscompares++;
                    $display("FAIL scoreboard: got ov=%b%b out1=%b out2=%b inv=%b%b expected ov=11 out1=%b out2=%b inv=%b%b",
                             ov1, ov2, out1, out2, inv1, inv2, e.o1, e.o2, e.inv, e.inv);
                end
            end
        end
    end

    // Drive one op at the current time and queue its expected result.
    task automatic apply(input logic [2:0] opc, input logic [2:0] a, input logic [2:0] b,
                         input logic ci, input logic si, input logic dir,
                         input logic ra, input logic rb, input logic ba, input logic bb,
                         input logic clr, input logic [5:0] e1, input logic [5:0] e2,
                         input logic einv);
        exp_t e;
        opcode = opc; A = a; B = b; cin = ci; serial_in = si; direction = dir;
        red_op_A = ra; red_op_B = rb; bypass_A = ba; bypass_B = bb;
        err_clr = clr; in_valid = 1'b1;
        e.o1 = e1; e.o2 = e2; e.inv = einv;
        exp_q.push_back(e);
    endtask

    task automatic send(input logic [2:0] opc, input logic [2:0] a, input logic [2:0] b,
                        input logic ci, input logic si, input logic dir,
                        input logic ra, input logic rb, input logic ba, input logic bb,
                        input logic clr, input logic [5:0] e1, input logic [5:0] e2,
                        input logic einv);
        @(negedge clk);
        apply(opc, a, b, ci, si, dir, ra, rb, ba, bb, clr, e1, e2, einv);
    endtask

    task automatic send_op(input logic [2:0] opc, input logic [2:0] a, input logic [2:0] b,
                           input logic ci, input logic si, input logic dir,
                           input logic [5:0] e, input logic einv);
        send(opc, a, b, ci, si, dir, 0, 0, 0, 0, 0, e, e, einv);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        err_clr  = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 12; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
            #1;
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain_timeout: got %0d pending results expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_err(input string name);
        vectors++;
        if (err1 !== 8'(exp_err1) || err2 !== 2'(exp_err2)) begin
            miscompares++;
            $display("FAIL %s: got err1=%0d err2=%0d expected err1=%0d err2=%0d",
                     name, err1, err2, exp_err1, exp_err2);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; cin = 0; serial_in = 0;
        red_op_A = 0; red_op_B = 0; opcode = '0; bypass_A = 0; bypass_B = 0;
        direction = 0; err_clr = 0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({out1, out2, ov1, ov2, inv1, inv2, leds1, leds2, err1, err2} !== '0) begin
            miscompares++;
            $display("FAIL reset_state: got out=%b/%b ov=%b%b inv=%b%b leds=%h/%h err=%0d/%0d expected all 0",
                     out1, out2, ov1, ov2, inv1, inv2, leds1, leds2, err1, err2);
        end
        rst = 1'b0;
    endtask

    task automatic test_add();
        send_op(3'd2, 3'd3, 3'd2, 1, 0, 0, 6'b000110, 0);
        idle();
        vectors++;
        if (ov1 !== 1'b0) begin
            miscompares++;
            $display("FAIL add_latency_early: got out_valid=%b expected 0", ov1);
        end
        @(negedge clk);
        vectors++;
        if ({ov1, out1, inv1, leds1} !== {1'b1, 6'b000110, 1'b0, 16'h0000}) begin
            miscompares++;
            $display("FAIL add_result: got ov=%b out=%b inv=%b leds=%h expected ov=1 out=000110 inv=0 leds=0000",
                     ov1, out1, inv1, leds1);
        end
        @(negedge clk);
        vectors++;
        if (ov1 !== 1'b0) begin
            miscompares++;
            $display("FAIL add_pulse_width: got out_valid=%b expected 0", ov1);
        end
        // -4 + -4 + 1 = -7
        send_op(3'd2, 3'b100, 3'b100, 1, 0, 0, 6'b111001, 0);
        idle();
        drain();
    endtask

    task automatic test_mul_bypass_logic();
        send_op(3'd3, 3'b100, 3'b011, 0, 0, 0, 6'b110100, 0);                       // -4*3 = -12
        send(3'd0, 3'b110, 3'b001, 0, 0, 0, 0, 0, 1, 1, 0, 6'b111110, 6'b000001, 0); // both bypass
        send(3'd2, 3'b001, 3'b101, 0, 0, 0, 0, 0, 0, 1, 0, 6'b111101, 6'b111101, 0); // bypass_B -3
        send(3'd0, 3'b000, 3'b100, 0, 0, 0, 1, 1, 0, 0, 0, 6'b000000, 6'b000001, 0); // OR reduce, prio
        send(3'd1, 3'b111, 3'b000, 0, 0, 0, 1, 0, 0, 0, 0, 6'b000001, 6'b000001, 0); // XOR reduce A
        send_op(3'd1, 3'b101, 3'b011, 0, 0, 0, 6'b000110, 0);                       // bitwise XOR
        send_op(3'd0, 3'b100, 3'b001, 0, 0, 0, 6'b000101, 0);                       // bitwise OR
        idle();
        drain();
    endtask

    task automatic test_shift_rotate();
        send(3'd0, 3'b001, 3'b000, 0, 0, 0, 0, 0, 1, 0, 0, 6'b000001, 6'b000001, 0);
        send_op(3'd4, 3'b111, 3'b111, 0, 1, 1, 6'b000011, 0);  // shift left, fill 1
        send_op(3'd5, 3'b111, 3'b111, 0, 1, 0, 6'b100001, 0);  // rotate right
        send_op(3'd4, 3'b000, 3'b000, 0, 0, 0, 6'b010000, 0);  // shift right, fill 0
        send_op(3'd5, 3'b000, 3'b000, 0, 0, 1, 6'b100000, 0);  // rotate left
        send_op(3'd5, 3'b000, 3'b000, 0, 0, 1, 6'b000001, 0);  // rotate left wraps MSB
        idle();
        drain();
    endtask

    task automatic test_invalid_blink();
        logic [15:0] e1, e2;
        send_op(3'd6, 3'b011, 3'b010, 0, 0, 0, 6'b000000, 1);
        idle();
        @(negedge clk);   // invalid rises here: blink cycle 0
        for (int c = 0; c <= 8; c++) begin
            if (c > 0) @(negedge clk);
            e1 = (c % 2 == 1) ? 16'hFFFF : 16'h0000;
            e2 = ((c / 4) % 2 == 1) ? 16'hFFFF : 16'h0000;
            vectors++;
            if (leds1 !== e1 || leds2 !== e2 || inv1 !== 1'b1 || inv2 !== 1'b1) begin
                miscompares++;
                $display("FAIL blink_c%0d: got leds=%h/%h inv=%b%b expected leds=%h/%h inv=11",
                         c, leds1, leds2, inv1, inv2, e1, e2);
            end
            // Second invalid op mid-blink must not restart the phase.
            if (c == 1) apply(3'd7, 3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 6'b0, 6'b0, 1);
            if (c == 2) in_valid = 1'b0;
        end
        exp_err1 = 2; exp_err2 = 2;
        check_err("blink_err_cnt");
        send_op(3'd2, 3'b001, 3'b001, 0, 0, 0, 6'b000010, 0);
        idle();
        @(negedge clk);
        vectors++;
        if (leds1 !== 16'h0 || leds2 !== 16'h0 || inv1 !== 1'b0 || inv2 !== 1'b0) begin
            miscompares++;
            $display("FAIL blink_cleared: got leds=%h/%h inv=%b%b expected leds=0000/0000 inv=00",
                     leds1, leds2, inv1, inv2);
        end
        drain();
    endtask

    task automatic test_err_cnt();
        send(3'd2, 3'b011, 3'b001, 0, 0, 0, 1, 0, 0, 0, 0, 6'b0, 6'b0, 1);  // red_op with ADD
        idle();
        drain();
        exp_err1 = 3; exp_err2 = 3;
        check_err("err_red_op");
        for (int i = 0; i < 5; i++)
            send_op(3'd7, 3'(i), 3'd1, 0, 0, 0, 6'b0, 1);
        idle();
        drain();
        exp_err1 = 8; exp_err2 = 3;
        check_err("err_saturate");
        send(3'd6, 3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 0, 1, 6'b0, 6'b0, 1);  // clear wins
        idle();
        drain();
        exp_err1 = 0; exp_err2 = 0;
        check_err("err_clear_wins");
        send_op(3'd6, 3'b000, 3'b000, 0, 0, 0, 6'b0, 1);
        idle();
        drain();
        exp_err1 = 1; exp_err2 = 1;
        check_err("err_after_clear");
    endtask

    task automatic test_reset_mid();
        send_op(3'd6, 3'b000, 3'b000, 0, 0, 0, 6'b0, 1);
        idle();
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (leds1 !== 16'hFFFF) begin
            miscompares++;
            $display("FAIL pre_reset_blink: got leds=%h expected ffff", leds1);
        end
        apply(3'd2, 3'b011, 3'b011, 1, 0, 0, 0, 0, 0, 0, 0, 6'b000111, 6'b000111, 0);
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        vectors++;
        if ({out1, out2, ov1, ov2, inv1, inv2, leds1, leds2, err1, err2} !== '0) begin
            miscompares++;
            $display("FAIL mid_reset: got out=%b/%b ov=%b%b inv=%b%b leds=%h/%h err=%0d/%0d expected all 0",
                     out1, out2, ov1, ov2, inv1, inv2, leds1, leds2, err1, err2);
        end
        exp_q.delete();
        exp_err1 = 0; exp_err2 = 0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vectors++;
            if (ov1 !== 1'b0 || ov2 !== 1'b0 || leds1 !== 16'h0 || out1 !== 6'b0) begin
                miscompares++;
                $display("FAIL post_reset_%0d: got ov=%b%b leds=%h out=%b expected ov=00 leds=0000 out=000000",
                         i, ov1, ov2, leds1, out1);
            end
        end
        send_op(3'd2, 3'b010, 3'b001, 0, 0, 0, 6'b000011, 0);
        idle();
        drain();
        check_err("post_reset_err");
    endtask

    initial begin
        test_reset();
        test_add();
        test_mul_bypass_logic();
        test_shift_rotate();
        test_invalid_blink();
        test_err_cnt();
        test_reset_mid();
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
